// File: rtl/aes256_key_expand_if.sv
// Port bundle for the AES-256 key schedule engine: the start/key request and
// the round-key valid/ready stream towards the round datapath.
interface aes256_key_expand_if #(
  parameter int RK_IDX_W = 4
);
  logic                start_i;
  logic [255:0]        key_i;
  logic                busy_o;
  logic [127:0]        rk_o;
  logic [RK_IDX_W-1:0] rk_idx_o;
  logic                rk_valid_o;
  logic                rk_ready_i;
  logic                done_o;

  modport master (
    output start_i, key_i, rk_ready_i,
    input  busy_o, rk_o, rk_idx_o, rk_valid_o, done_o
  );

  modport slave (
    input  start_i, key_i, rk_ready_i,
    output busy_o, rk_o, rk_idx_o, rk_valid_o, done_o
  );
endinterface

// File: rtl/aes256_key_expand.sv
// Sequential AES-256 key schedule: one schedule word per GEN step, round keys
// streamed over valid/ready. Optional macro KEXP_SBOX_PIPE_EN registers SubWord.
module s_box (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), then the AES affine map.
  function automatic logic [7:0] sub_byte(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign s_o = sub_byte(a_i);
endmodule

module aes256_key_expand #(
  parameter int NR       = 14,
  parameter int RK_IDX_W = 4
) (
  input logic                clk,
  input logic                rst,
  aes256_key_expand_if.slave kx
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY0,
    S_KEY1,
    S_GEN,
    S_OUT
  } state_e;

  localparam logic [RK_IDX_W-1:0] LAST_IDX = RK_IDX_W'(NR);

  state_e state_q, state_d;
  logic         done_q, done_d;
  logic [255:0] win_q;            // w[i-8] in [255:224] ... w[i-1] in [31:0]
  logic [127:0] acc_q;
  logic [5:0]   i_q;
  logic         load, word_en, step;
  logic [127:0] rk;
  logic [RK_IDX_W-1:0] rk_idx;
  logic         rk_valid;
  logic [3:0]   out_idx;

  logic [31:0] win7, rot, sub_in, sub_out, sub_w, temp, w_new;
  logic [7:0]  rcon;

  assign win7   = win_q[31:0];
  assign rot    = {win7[23:0], win7[31:24]};
  assign sub_in = (i_q[2] == 1'b0) ? rot : win7;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    s_box u_s_box (.a_i(sub_in[8*b +: 8]), .s_o(sub_out[8*b +: 8]));
  end

`ifdef KEXP_SBOX_PIPE_EN
  logic [31:0] sub_q;
  logic        phase_q;

  // Phase 0 captures SubWord, phase 1 retires the word; i is stable across both.
  always_ff @(posedge clk) sub_q <= sub_out;
  assign sub_w = sub_q;
  assign step  = phase_q;
`else
  assign sub_w = sub_out;
  assign step  = 1'b1;
`endif

  // i/8 runs 1..7 over the schedule, so Rcon is a plain power of two.
  assign rcon    = 8'h01 << (i_q[5:3] - 3'd1);
  assign temp    = (i_q[1:0] != 2'd0) ? win7 :
                   (i_q[2] == 1'b0)   ? (sub_w ^ {rcon, 24'h0}) : sub_w;
  assign w_new   = win_q[255:224] ^ temp;
  assign out_idx = i_q[5:2] - 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
`ifdef KEXP_SBOX_PIPE_EN
      phase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
`ifdef KEXP_SBOX_PIPE_EN
      phase_q <= (state_q == S_GEN) ? ~phase_q : 1'b0;
`endif
    end
  end

  // NOTE: the key window, accumulator and counter carry no reset; they are only
  // observed after a load, and the outputs are forced to zero outside valid states.
  always_ff @(posedge clk) begin
    if (load) begin
      win_q <= kx.key_i;
      i_q   <= 6'd8;
    end else if (word_en) begin
      win_q <= {win_q[223:0], w_new};
      acc_q <= {acc_q[95:0], w_new};
      i_q   <= i_q + 6'd1;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    load     = 1'b0;
    word_en  = 1'b0;
    rk       = '0;
    rk_idx   = '0;
    rk_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (kx.start_i) begin
          load    = 1'b1;
          state_d = S_KEY0;
        end
      end
      S_KEY0: begin
        rk_valid = 1'b1;
        rk       = win_q[255:128];
        if (kx.rk_ready_i) state_d = S_KEY1;
      end
      S_KEY1: begin
        rk_valid = 1'b1;
        rk       = win_q[127:0];
        rk_idx   = RK_IDX_W'(1);
        if (kx.rk_ready_i) state_d = S_GEN;
      end
      S_GEN: begin
        word_en = step;
        if (step && i_q[1:0] == 2'd3) state_d = S_OUT;
      end
      S_OUT: begin
        rk_valid = 1'b1;
        rk       = acc_q;
        rk_idx   = RK_IDX_W'(out_idx);
        if (kx.rk_ready_i) begin
          if (rk_idx == LAST_IDX) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_GEN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign kx.busy_o     = (state_q != S_IDLE);
  assign kx.done_o     = done_q;
  assign kx.rk_o       = rk;
  assign kx.rk_idx_o   = rk_idx;
  assign kx.rk_valid_o = rk_valid;
endmodule

// File: tb/tb_aes256_key_expand.sv
// Directed bench for aes256_key_expand: FIPS-197 vectors, backpressure,
// mid-run reset, held start and key-change immunity.
module tb_aes256_key_expand;
`ifdef KEXP_SBOX_PIPE_EN
  localparam int EXP_DONE = 120;
`else
  localparam int EXP_DONE = 68;
`endif

  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] A3_RK0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] A3_RK1  = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] A3_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] A3_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [127:0] ZERO_RK2 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] C3_RK0  = 128'h000102030405060708090a0b0c0d0e0f;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [127:0] got_rk   [0:14];
  logic [127:0] model_rk [0:14];
  int           got_n;
  int           done_lat;

  aes256_key_expand_if kx ();

  aes256_key_expand dut (
    .clk (clk),
    .rst (rst),
    .kx  (kx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference schedule: polynomial multiply with explicit reduction, inverse by search.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (15'(a) << k);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11b << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] s;
    inv = '0;
    c   = 8'h63;
    if (a != 8'h00)
      for (int b = 1; b < 256; b++) if (ref_mul(a, 8'(b)) == 8'h01) inv = 8'(b);
    for (int k = 0; k < 8; k++)
      s[k] = inv[k] ^ inv[(k+4)%8] ^ inv[(k+5)%8] ^ inv[(k+6)%8] ^ inv[(k+7)%8] ^ c[k];
    return s;
  endfunction

  function automatic logic [31:0] ref_subword(input logic [31:0] x);
    return {ref_sbox(x[31:24]), ref_sbox(x[23:16]), ref_sbox(x[15:8]), ref_sbox(x[7:0])};
  endfunction

  task automatic build_model(input logic [255:0] key);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int k = 0; k < 8; k++) w[k] = key[255 - 32*k -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = ref_subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0};
      end else if (i % 8 == 4) begin
        t = ref_subword(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Drives one expansion and records every handshaken key; checks busy, index
  // order and hold-under-stall along the way. Returns in the done_o cycle.
  task automatic run_expansion(input logic [255:0] key, input bit rand_ready,
                               input bit hold_start, input bit flip_key);
    int           start_cyc;
    bit           seen_done;
    bit           prev_stall;
    logic [127:0] prev_rk;
    logic [3:0]   prev_idx;
    got_n      = 0;
    done_lat   = -1;
    seen_done  = 1'b0;
    prev_stall = 1'b0;
    prev_rk    = '0;
    prev_idx   = '0;
    @(negedge clk);
    kx.key_i      = key;
    kx.start_i    = 1'b1;
    kx.rk_ready_i = 1'b1;
    start_cyc     = cyc;
    for (int n = 0; n < 1000 && !seen_done; n++) begin
      @(negedge clk);
      if (!hold_start) kx.start_i = 1'b0;
      if (flip_key) kx.key_i = '1;
      if (prev_stall) begin
        checks++;
        if (kx.rk_valid_o !== 1'b1 || kx.rk_o !== prev_rk || kx.rk_idx_o !== prev_idx) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b idx=%0d rk=%h, expected valid=1 idx=%0d rk=%h",
                   kx.rk_valid_o, kx.rk_idx_o, kx.rk_o, prev_idx, prev_rk);
        end
      end
      if (kx.done_o === 1'b1) begin
        seen_done = 1'b1;
        done_lat  = cyc - start_cyc;
        checks++;
        if (kx.busy_o !== 1'b0) begin
          errors++;
          $display("FAIL busy_in_done: got %b expected 0", kx.busy_o);
        end
      end else begin
        checks++;
        if (kx.busy_o !== 1'b1) begin
          errors++;
          $display("FAIL busy_during_run: got %b expected 1 at cycle %0d", kx.busy_o, cyc);
        end
        kx.rk_ready_i = rand_ready ? ($urandom % 3 != 0) : 1'b1;
        if (kx.rk_valid_o === 1'b1 && kx.rk_ready_i) begin
          checks++;
          if (got_n >= 15 || kx.rk_idx_o !== 4'(got_n)) begin
            errors++;
            $display("FAIL rk_order: got idx %0d expected %0d", kx.rk_idx_o, got_n);
          end
          if (got_n < 15) got_rk[got_n] = kx.rk_o;
          got_n++;
        end
        prev_stall = (kx.rk_valid_o === 1'b1) && !kx.rk_ready_i;
        prev_rk    = kx.rk_o;
        prev_idx   = kx.rk_idx_o;
      end
    end
    if (!seen_done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done_o within budget, expected one");
    end
  endtask

  task automatic compare_all(input string tag);
    checks++;
    if (got_n != 15) begin
      errors++;
      $display("FAIL %s_count: got %0d keys expected 15", tag, got_n);
    end
    for (int r = 0; r < 15 && r < got_n; r++) begin
      checks++;
      if (got_rk[r] !== model_rk[r]) begin
        errors++;
        $display("FAIL %s_rk%0d: got %h expected %h", tag, r, got_rk[r], model_rk[r]);
      end
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    kx.start_i    = 1'b0;
    kx.key_i      = '0;
    kx.rk_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (kx.busy_o !== 1'b0 || kx.rk_valid_o !== 1'b0 || kx.done_o !== 1'b0 ||
        kx.rk_o !== 128'h0 || kx.rk_idx_o !== 4'h0) begin
      errors++;
      $display("FAIL reset_values: got busy=%b valid=%b done=%b idx=%0d rk=%h expected all zero",
               kx.busy_o, kx.rk_valid_o, kx.done_o, kx.rk_idx_o, kx.rk_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_fips_a3();
    build_model(KEY_A3);
    run_expansion(KEY_A3, 1'b0, 1'b0, 1'b0);
    compare_all("a3");
    checks++;
    if (got_rk[0] !== A3_RK0) begin errors++; $display("FAIL a3_vec_rk0: got %h expected %h", got_rk[0], A3_RK0); end
    checks++;
    if (got_rk[1] !== A3_RK1) begin errors++; $display("FAIL a3_vec_rk1: got %h expected %h", got_rk[1], A3_RK1); end
    checks++;
    if (got_rk[2] !== A3_RK2) begin errors++; $display("FAIL a3_vec_rk2: got %h expected %h", got_rk[2], A3_RK2); end
    checks++;
    if (got_rk[14] !== A3_RK14) begin errors++; $display("FAIL a3_vec_rk14: got %h expected %h", got_rk[14], A3_RK14); end
    checks++;
    if (done_lat != EXP_DONE) begin
      errors++;
      $display("FAIL a3_done_latency: got %0d expected %0d", done_lat, EXP_DONE);
    end
    @(negedge clk);
    checks++;
    if (kx.done_o !== 1'b0 || kx.rk_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL a3_after_done: got done=%b valid=%b expected 0 0", kx.done_o, kx.rk_valid_o);
    end
  endtask

  task automatic test_backpressure();
    build_model(KEY_A3);
    run_expansion(KEY_A3, 1'b1, 1'b0, 1'b0);
    compare_all("bp");
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    @(negedge clk);
    kx.key_i      = KEY_A3;
    kx.start_i    = 1'b1;
    kx.rk_ready_i = 1'b1;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      kx.start_i = 1'b0;
      if (kx.rk_valid_o === 1'b1 && kx.rk_idx_o === 4'd7) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midrst_reach_rk7: got no rk7 within budget, expected one");
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (kx.rk_valid_o !== 1'b0 || kx.busy_o !== 1'b0 || kx.rk_o !== 128'h0 || kx.done_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got valid=%b busy=%b done=%b rk=%h expected zeros",
               kx.rk_valid_o, kx.busy_o, kx.done_o, kx.rk_o);
    end
    rst = 1'b0;
    build_model(KEY_C3);
    run_expansion(KEY_C3, 1'b0, 1'b0, 1'b0);
    checks++;
    if (got_rk[0] !== C3_RK0) begin
      errors++;
      $display("FAIL midrst_new_rk0: got %h expected %h", got_rk[0], C3_RK0);
    end
    compare_all("c3");
  endtask

  task automatic test_start_held();
    bit drained;
    drained = 1'b0;
    build_model(KEY_A3);
    run_expansion(KEY_A3, 1'b0, 1'b1, 1'b0);
    compare_all("held");
    checks++;
    if (done_lat != EXP_DONE) begin
      errors++;
      $display("FAIL held_done_latency: got %0d expected %0d", done_lat, EXP_DONE);
    end
    @(negedge clk);
    checks++;
    if (kx.rk_valid_o !== 1'b1 || kx.rk_idx_o !== 4'd0 || kx.rk_o !== model_rk[0] ||
        kx.busy_o !== 1'b1 || kx.done_o !== 1'b0) begin
      errors++;
      $display("FAIL held_restart: got valid=%b idx=%0d busy=%b done=%b rk=%h expected 1 0 1 0 %h",
               kx.rk_valid_o, kx.rk_idx_o, kx.busy_o, kx.done_o, kx.rk_o, model_rk[0]);
    end
    kx.start_i = 1'b0;
    for (int n = 0; n < 300 && !drained; n++) begin
      @(negedge clk);
      if (kx.done_o === 1'b1) drained = 1'b1;
    end
    checks++;
    if (!drained) begin
      errors++;
      $display("FAIL held_second_done: got no done_o within budget, expected one");
    end
  endtask

  task automatic test_zero_key();
    build_model(256'h0);
    run_expansion(256'h0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (got_rk[2] !== ZERO_RK2) begin
      errors++;
      $display("FAIL zero_rk2: got %h expected %h", got_rk[2], ZERO_RK2);
    end
    compare_all("zero");
    kx.key_i = '0;
  endtask

  initial begin
    test_reset();
    test_fips_a3();
    test_backpressure();
    test_reset_mid();
    test_start_held();
    test_zero_key();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
